openhw_cachebusresp: RTL
========================

# openhw_cachebusresp

Bus-side responder for the cache line-transfer handshake. It accepts line fetch and line writeback requests on `CacheBusRW` from a cache controller and splits each line into `LINELEN/BEATLEN` beat transactions on a simple request/ready memory port. It assembles fetched beats into `FetchBuffer` and pulses `CacheBusAck` when the last beat completes. It sits between the cache controller and the memory/bus adapter.

## Interface

Parameters:
- `PA_BITS`, 32: physical address width.
- `LINELEN`, 256: cache line width in bits.
- `BEATLEN`, 64: memory beat width in bits. `LINELEN/BEATLEN` is a power of 2 and at least 2.

Ports:
- `clk`, in, 1: clock. Single clock domain.
- `reset`, in, 1: asynchronous, active-low reset.
- `CacheBusRW`, in, 2: bit [1] is line fetch request; bit [0] is line writeback request.
- `CacheBusAdr`, in, PA_BITS: line address. Low `log2(LINELEN/8)` bits are ignored.
- `CacheLineWData`, in, LINELEN: writeback line data.
- `CacheBusAck`, out, 1: one-cycle pulse marking completion of the current line operation.
- `FetchBuffer`, out, LINELEN: assembled fetched line.
- `BusBusy`, out, 1: high whenever the block is not in IDLE.
- `MemReq`, out, 1: beat request valid.
- `MemWrite`, out, 1: beat is a write.
- `MemAdr`, out, PA_BITS: beat byte address.
- `MemWData`, out, BEATLEN: write beat data.
- `MemReady`, in, 1: beat accepted this cycle. For reads, it also signals that `MemRData` is valid.
- `MemRData`, in, BEATLEN: read beat data.

## Operation

**Definitions**
- `BEATS = LINELEN/BEATLEN`.
- `BeatCount` is a `log2(BEATS)`-bit counter.
- `LineAdr` is a register holding `CacheBusAdr` with the low `log2(LINELEN/8)` bits zeroed.
- `WLine` is a LINELEN-bit register.
- `MemAdr = LineAdr | (BeatCount << log2(BEATLEN/8))`.
- Beat 0 is the lowest address and maps to bits `[BEATLEN-1:0]`.

**State machine: IDLE, WRITE, READ**

IDLE:
- If `CacheBusRW[0]`: capture `LineAdr` and `WLine <= CacheLineWData`, clear `BeatCount`, and go to WRITE.
- Otherwise, if `CacheBusRW[1]`: capture `LineAdr`, clear `BeatCount`, and go to READ.
- Write has priority when both bits are set. The pending read is served after the write completes, because the cache holds `CacheBusRW[1]` at ack time.

WRITE:
- `MemReq=1`, `MemWrite=1`, `MemWData = WLine[BeatCount*BEATLEN +: BEATLEN]`.
- On `MemReady`, `BeatCount` increments.
- On `MemReady` with `BeatCount==BEATS-1`:
  - `CacheBusAck=1` in that same cycle.
  - If `CacheBusRW[1]` is high in that cycle: recapture `LineAdr` from `CacheBusAdr`, clear `BeatCount`, and go to READ. This handles back-to-back writeback then fetch with no IDLE cycle.
  - Otherwise go to IDLE.

READ:
- `MemReq=1`, `MemWrite=0`.
- On `MemReady`: write `FetchBuffer[BeatCount*BEATLEN +: BEATLEN] <= MemRData` and increment `BeatCount`.
- On the last beat: `CacheBusAck=1` in that cycle, then go to IDLE.

**General rules**
- `CacheBusRW` is ignored outside IDLE, except in the WRITE→READ chaining case above.
- Once started, an operation always completes. There is no abort path.
- `FetchBuffer` holds its value between fetches. Only the beat slots written by a fetch change.
- `BeatCount` wraps modulo BEATS and is don't-care in IDLE.

**Reset (`reset=0`, asynchronous)**
- State goes to IDLE immediately, mid-operation included.
- Forced low: `MemReq`, `MemWrite`, `CacheBusAck`, `BusBusy`.
- Cleared to 0: `FetchBuffer`, `WLine`, `LineAdr`, `BeatCount`.
- `MemAdr` and `MemWData` are 0 while in reset.
- An interrupted transaction produces no ack.

## Timing

- All outputs are Moore decodes of state and registers, except `CacheBusAck`, which is the combinational AND of state, last beat and `MemReady`.
- Request accepted in IDLE at cycle 0:
  - `MemReq` is first high in cycle 1.
  - With `MemReady` tied high, beats occur in cycles 1..BEATS.
  - `CacheBusAck` is high in cycle BEATS.
  - The complete `FetchBuffer` is visible from cycle BEATS+1.
- Each `MemReady` stall cycle delays ack by exactly one cycle.
- `MemReq`, `MemAdr`, `MemWData` and `MemWrite` stay stable while `MemReq=1` and `MemReady=0`.
- Writeback followed by fetch: write beats in cycles 1..BEATS, ack at cycle BEATS, read beats in cycles BEATS+1..2·BEATS, second ack at cycle 2·BEATS.
- Maximum throughput is one beat per cycle.

## Test plan

- **Reset values:** hold `reset=0` and then release. Check all outputs 0 and `BusBusy=0`. Then assert `CacheBusRW=2'b10`, `CacheBusAdr=0x1234_5678`, `MemReady=1`. Check `MemAdr` sequence 0x1234_5660/68/70/78 and ack in cycle 4.
- **Fetch assembly with stalls:** fetch with `MemRData` beats 0xA0..0xA3 and `MemReady` low for 2 cycles before beat 2. Check ack in cycle 6 and `FetchBuffer={0xA3,0xA2,0xA1,0xA0}` per 64-bit slot.
- **Writeback:** `CacheBusRW=01`, `CacheLineWData={64'hD,64'hC,64'hB,64'hA}`. Change `CacheLineWData` after cycle 0. Check `MemWData` A,B,C,D from the captured line, `MemWrite=1`, and a single ack pulse.
- **Chained evict-fetch:** `CacheBusRW=01`, with `CacheBusRW` driven to 10 in the ack cycle. Check READ starts in the next cycle with no IDLE, `MemWrite=0` and the new address. Expect two ack pulses total, at cycles 4 and 8.
- **Reset mid-operation:** assert `reset=0` during beat 2 of a fetch. Check `MemReq` drops asynchronously, no ack occurs, and `FetchBuffer=0`. A fresh fetch after release completes normally.
- **Request while busy:** toggle `CacheBusRW=01` during READ. Check it is ignored, so no write beats occur before the READ ack.

Source files
------------

// File: rtl/openhw_cachebusresp.sv
// Bus-side responder for cache line transfers: splits each line fetch or writeback
// into BEATS memory beats and assembles fetched beats into FetchBuffer.
module openhw_cachebusresp #(
    parameter int PA_BITS = 32,
    parameter int LINELEN = 256,
    parameter int BEATLEN = 64
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [1:0]         CacheBusRW,
    input  logic [PA_BITS-1:0] CacheBusAdr,
    input  logic [LINELEN-1:0] CacheLineWData,
    output logic               CacheBusAck,
    output logic [LINELEN-1:0] FetchBuffer,
    output logic               BusBusy,
    output logic               MemReq,
    output logic               MemWrite,
    output logic [PA_BITS-1:0] MemAdr,
    output logic [BEATLEN-1:0] MemWData,
    input  logic               MemReady,
    input  logic [BEATLEN-1:0] MemRData
);
    localparam int BEATS = LINELEN / BEATLEN;
    localparam int BCW   = $clog2(BEATS);
    localparam int LOFF  = $clog2(LINELEN / 8);
    localparam int BOFF  = $clog2(BEATLEN / 8);

    localparam logic [BCW-1:0]     LAST_BEAT = BCW'(BEATS - 1);
    localparam logic [PA_BITS-1:0] LINE_MASK = ~((PA_BITS'(1) << LOFF) - PA_BITS'(1));

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2
    } state_e;

    state_e               state_q;
    logic [BCW-1:0]       beat_q;
    logic [PA_BITS-1:0]   line_adr_q;
    logic [LINELEN-1:0]   wline_q;
    logic [LINELEN-1:0]   fbuf_q;
    logic [LINELEN-1:0]   fbuf_d;
    logic                 req_q;
    logic                 write_q;
    logic                 busy_q;
    logic                 last_beat;

    assign last_beat   = (beat_q == LAST_BEAT);
    assign CacheBusAck = (state_q != IDLE) & MemReady & last_beat;

    assign MemReq      = req_q;
    assign MemWrite    = write_q;
    assign BusBusy     = busy_q;
    assign FetchBuffer = fbuf_q;
    assign MemAdr      = line_adr_q | (PA_BITS'(beat_q) << BOFF);
    assign MemWData    = wline_q[int'(beat_q) * BEATLEN +: BEATLEN];

    // Only the slot of the beat being accepted changes; the rest of the line holds.
    always_comb begin
        fbuf_d = fbuf_q;
        if (state_q == READ && MemReady) begin
            fbuf_d[int'(beat_q) * BEATLEN +: BEATLEN] = MemRData;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fbuf_q <= '0;
        end else begin
            fbuf_q <= fbuf_d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            beat_q     <= '0;
            line_adr_q <= '0;
            wline_q    <= '0;
            req_q      <= 1'b0;
            write_q    <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (CacheBusRW[0]) begin
                        line_adr_q <= CacheBusAdr & LINE_MASK;
                        wline_q    <= CacheLineWData;
                        beat_q     <= '0;
                        state_q    <= WRITE;
                        req_q      <= 1'b1;
                        write_q    <= 1'b1;
                        busy_q     <= 1'b1;
                    end else if (CacheBusRW[1]) begin
                        line_adr_q <= CacheBusAdr & LINE_MASK;
                        beat_q     <= '0;
                        state_q    <= READ;
                        req_q      <= 1'b1;
                        write_q    <= 1'b0;
                        busy_q     <= 1'b1;
                    end
                end
                WRITE: begin
                    if (MemReady) begin
                        beat_q <= beat_q + BCW'(1);
                        if (last_beat) begin
                            // A fetch held by the cache at ack time chains straight into READ.
                            if (CacheBusRW[1]) begin
                                line_adr_q <= CacheBusAdr & LINE_MASK;
                                beat_q     <= '0;
                                state_q    <= READ;
                                write_q    <= 1'b0;
                            end else begin
                                state_q <= IDLE;
                                req_q   <= 1'b0;
                                write_q <= 1'b0;
                                busy_q  <= 1'b0;
                            end
                        end
                    end
                end
                READ: begin
                    if (MemReady) begin
                        beat_q <= beat_q + BCW'(1);
                        if (last_beat) begin
                            state_q <= IDLE;
                            req_q   <= 1'b0;
                            write_q <= 1'b0;
                            busy_q  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                    req_q   <= 1'b0;
                    write_q <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

endmodule
